// File: rtl/ssd1306_spi_receiver.sv
// ssd1306_spi_receiver: passive SSD1306 4-wire SPI decoder rebuilding the GDDRAM write stream
module ssd1306_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int COL_MAX     = 127,
  parameter int PAGE_MAX    = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ioSclk,
  input  logic       ioSdin,
  input  logic       ioCs,
  input  logic       ioDc,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       rx_valid,
  output logic [9:0] pix_addr,
  output logic [7:0] pix_data,
  output logic       pix_we,
  output logic       frame_done
);
  typedef enum logic [2:0] {IDLE, COL_A, COL_B, PAGE_A, PAGE_B, SKIP1} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_q, sclk_d, sdin_q, sdin_d, cs_q, cs_d, dc_q, dc_d;
  logic sclk_dly_q, sclk_dly_d;
  logic sclk_s, sdin_s, cs_s, dc_s, rise;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic done_q, done_d, dc_lat_q, dc_lat_d;
  logic [6:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [2:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [7:0] rx_byte_q, rx_byte_d, pix_data_q, pix_data_d;
  logic [9:0] pix_addr_q, pix_addr_d;
  logic rx_dc_q, rx_dc_d, rx_valid_q, rx_valid_d, pix_we_q, pix_we_d, frame_done_q, frame_done_d;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign sdin_s = sdin_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign dc_s   = dc_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_dly_q;
  // Synchronize the bus, shift bits in, then decode each completed byte one cycle later
  always_comb begin
    sclk_d       = {sclk_q[SYNC_STAGES-2:0], ioSclk};
    sdin_d       = {sdin_q[SYNC_STAGES-2:0], ioSdin};
    cs_d         = {cs_q[SYNC_STAGES-2:0], ioCs};
    dc_d         = {dc_q[SYNC_STAGES-2:0], ioDc};
    sclk_dly_d   = sclk_s;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    done_d       = 1'b0;
    dc_lat_d     = dc_lat_q;
    state_d      = state_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    rx_byte_d    = rx_byte_q;
    rx_dc_d      = rx_dc_q;
    rx_valid_d   = 1'b0;
    pix_addr_d   = pix_addr_q;
    pix_data_d   = pix_data_q;
    pix_we_d     = 1'b0;
    frame_done_d = 1'b0;
    if (rise && !cs_s) begin
      shreg_d   = {shreg_q[6:0], sdin_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      done_d    = bit_cnt_q == 3'd7;
      dc_lat_d  = bit_cnt_q == 3'd7 ? dc_s : dc_lat_q;
    end
    if (cs_s) bit_cnt_d = 3'd0;
    if (done_q) begin
      rx_byte_d  = shreg_q;
      rx_dc_d    = dc_lat_q;
      rx_valid_d = 1'b1;
      if (dc_lat_q) begin
        pix_we_d     = 1'b1;
        pix_data_d   = shreg_q;
        pix_addr_d   = {page_q, col_q};
        frame_done_d = col_q == col_end_q && page_q == page_end_q;
        col_d        = col_q == col_end_q ? col_start_q : col_q + 7'd1;
        page_d       = col_q != col_end_q ? page_q : page_q == page_end_q ? page_start_q : page_q + 3'd1;
      end else begin
        case (state_q)
          IDLE:    state_d = shreg_q == 8'h21 ? COL_A : shreg_q == 8'h22 ? PAGE_A :
                             shreg_q inside {8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB} ? SKIP1 : IDLE;
          COL_A:   begin col_start_d = shreg_q[6:0]; col_d = shreg_q[6:0]; state_d = COL_B; end
          COL_B:   begin col_end_d = shreg_q[6:0]; state_d = IDLE; end
          PAGE_A:  begin page_start_d = shreg_q[2:0]; page_d = shreg_q[2:0]; state_d = PAGE_B; end
          PAGE_B:  begin page_end_d = shreg_q[2:0]; state_d = IDLE; end
          default: state_d = IDLE;
        endcase
      end
    end
  end
  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_q       <= '0;
      sdin_q       <= '0;
      cs_q         <= '1;
      dc_q         <= '0;
      sclk_dly_q   <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      done_q       <= 1'b0;
      dc_lat_q     <= 1'b0;
      state_q      <= IDLE;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= 7'(COL_MAX);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= 3'(PAGE_MAX);
      rx_byte_q    <= '0;
      rx_dc_q      <= 1'b0;
      rx_valid_q   <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      pix_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sclk_q       <= sclk_d;
      sdin_q       <= sdin_d;
      cs_q         <= cs_d;
      dc_q         <= dc_d;
      sclk_dly_q   <= sclk_dly_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      done_q       <= done_d;
      dc_lat_q     <= dc_lat_d;
      state_q      <= state_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      rx_byte_q    <= rx_byte_d;
      rx_dc_q      <= rx_dc_d;
      rx_valid_q   <= rx_valid_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      pix_we_q     <= pix_we_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign rx_byte    = rx_byte_q;
  assign rx_dc      = rx_dc_q;
  assign rx_valid   = rx_valid_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign pix_we     = pix_we_q;
  assign frame_done = frame_done_q;
endmodule
